// File: rtl/udc_pkg.sv
// udc_pkg: shared register addresses, status codes, FSM states and bus command for the UDC host sequencer.
// Rev 1.0
`default_nettype none

package udc_pkg;

  localparam logic [1:0] ADDR_PLR = 2'd0;
  localparam logic [1:0] ADDR_ULR = 2'd1;
  localparam logic [1:0] ADDR_LLR = 2'd2;
  localparam logic [1:0] ADDR_CCR = 2'd3;

  typedef enum logic [1:0] {
    STATUS_OK          = 2'd0,
    STATUS_VERIFY_FAIL = 2'd1,
    STATUS_CNT_ERR     = 2'd2,
    STATUS_TIMEOUT     = 2'd3
  } udc_status_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_TURN  = 3'd2,
    ST_READ  = 3'd3,
    ST_START = 3'd4,
    ST_RUN   = 3'd5,
    ST_DONE  = 3'd6
  } udc_state_t;

  // Per-cycle request from the sequencer FSM to the bus driver.
  typedef struct packed {
    logic       idle;
    logic       write;
    logic       read;
    logic [1:0] addr;
    logic [7:0] wdata;
  } udc_bus_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udc_host_sequencer_if.sv
// udc_host_sequencer_if: configuration/status handshake and counter control signals of the host sequencer.
// Rev 1.0
`default_nettype none

interface udc_host_sequencer_if;
  import udc_pkg::*;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_plr;
  logic [7:0]  cfg_ulr;
  logic [7:0]  cfg_llr;
  logic [7:0]  cfg_ccr;
  logic        ncs;
  logic        nrd;
  logic        nwr;
  logic        a0;
  logic        a1;
  logic        start;
  logic        ec;
  logic        err;
  logic        dir;
  logic        done;
  udc_status_t status;
  logic [15:0] run_cycles;
  logic        last_dir;

  modport master (
    input  cfg_valid, cfg_plr, cfg_ulr, cfg_llr, cfg_ccr, ec, err, dir,
    output cfg_ready, ncs, nrd, nwr, a0, a1, start, done, status, run_cycles, last_dir
  );

  modport slave (
    output cfg_valid, cfg_plr, cfg_ulr, cfg_llr, cfg_ccr, ec, err, dir,
    input  cfg_ready, ncs, nrd, nwr, a0, a1, start, done, status, run_cycles, last_dir
  );

endinterface

`default_nettype wire

// File: rtl/udc_bus_driver.sv
// udc_bus_driver: registers the counter bus strobes/address and owns the din tristate.
// Rev 1.0
`default_nettype none

module udc_bus_driver
  import udc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  udc_bus_cmd_t cmd,
  output logic         ncs,
  output logic         nrd,
  output logic         nwr,
  output logic         a0,
  output logic         a1,
  inout  wire  [7:0]   din,
  output logic [7:0]   rdata
);

  logic [7:0] wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ncs     <= 1'b1;
      nrd     <= 1'b1;
      nwr     <= 1'b1;
      a0      <= 1'b0;
      a1      <= 1'b0;
      wdata_q <= 8'd0;
    end else begin
      ncs     <= cmd.idle;
      nwr     <= ~(cmd.write & ~cmd.idle);
      nrd     <= ~(cmd.read & ~cmd.idle);
      a1      <= cmd.addr[1];
      a0      <= cmd.addr[0];
      wdata_q <= cmd.wdata;
    end
  end

  // The drive enable is the registered write strobe itself, so the bus is
  // released on exactly the cycle the write strobe goes inactive.
  assign din   = nwr ? 8'bz : wdata_q;
  assign rdata = din;

endmodule

`default_nettype wire

// File: rtl/udc_host_sequencer.sv
// udc_host_sequencer: programs the up/down counter, optionally verifies it, starts it and supervises the run.
// Rev 1.0
`default_nettype none

module udc_host_sequencer
  import udc_pkg::*;
#(
  parameter bit          VERIFY  = 1'b1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  udc_host_sequencer_if.master bus,
  inout  wire  [7:0]           din
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  udc_state_t   state;
  udc_state_t   state_nxt;
  logic [1:0]   beat;
  logic [1:0]   beat_nxt;
  logic [1:0]   beat_inc;
  logic [7:0]   cap [4];
  logic         mismatch_q;
  logic         verify_bad;
  logic         start_q;
  logic         start_nxt;
  logic         done_q;
  logic         done_nxt;
  udc_status_t  status_q;
  udc_status_t  exit_status;
  logic         run_exit;
  logic [15:0]  run_cycles_q;
  logic         last_dir_q;
  logic         accept;
  logic [7:0]   rdata;
  udc_bus_cmd_t cmd;

  assign accept     = bus.cfg_valid && (state == ST_IDLE);
  assign beat_inc   = beat + 2'd1;
  assign verify_bad = mismatch_q | (rdata != cap[beat]);

  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    cmd         = '0;
    cmd.idle    = 1'b1;
    start_nxt   = 1'b0;
    done_nxt    = 1'b0;
    run_exit    = 1'b0;
    exit_status = STATUS_OK;
    case (state)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          state_nxt = ST_WRITE;
          beat_nxt  = ADDR_PLR;
          cmd.idle  = 1'b0;
          cmd.write = 1'b1;
          cmd.addr  = ADDR_PLR;
          cmd.wdata = bus.cfg_plr;
        end
      end
      ST_WRITE: begin
        cmd.idle = 1'b0;
        if (beat == ADDR_CCR) begin
          if (VERIFY) begin
            state_nxt = ST_TURN;
          end else begin
            state_nxt = ST_START;
            start_nxt = 1'b1;
          end
        end else begin
          beat_nxt  = beat_inc;
          cmd.write = 1'b1;
          cmd.addr  = beat_inc;
          cmd.wdata = cap[beat_inc];
        end
      end
      ST_TURN: begin
        state_nxt = ST_READ;
        beat_nxt  = ADDR_PLR;
        cmd.idle  = 1'b0;
        cmd.read  = 1'b1;
        cmd.addr  = ADDR_PLR;
      end
      ST_READ: begin
        if (beat == ADDR_CCR) begin
          if (verify_bad) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_START;
            start_nxt = 1'b1;
            cmd.idle  = 1'b0;
          end
        end else begin
          beat_nxt = beat_inc;
          cmd.idle = 1'b0;
          cmd.read = 1'b1;
          cmd.addr = beat_inc;
        end
      end
      ST_START: begin
        state_nxt = ST_RUN;
        cmd.idle  = 1'b0;
      end
      ST_RUN: begin
        // err outranks ec, and both outrank the timeout.
        run_exit = bus.err | bus.ec | (run_cycles_q == TIMEOUT_LAST);
        if (bus.err) begin
          exit_status = STATUS_CNT_ERR;
        end else if (bus.ec) begin
          exit_status = STATUS_OK;
        end else begin
          exit_status = STATUS_TIMEOUT;
        end
        if (run_exit) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          cmd.idle = 1'b0;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      beat         <= 2'd0;
      mismatch_q   <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= STATUS_OK;
      run_cycles_q <= 16'd0;
      last_dir_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cap[i] <= 8'd0;
      end
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      start_q <= start_nxt;
      done_q  <= done_nxt;
      if (accept) begin
        cap[ADDR_PLR] <= bus.cfg_plr;
        cap[ADDR_ULR] <= bus.cfg_ulr;
        cap[ADDR_LLR] <= bus.cfg_llr;
        cap[ADDR_CCR] <= bus.cfg_ccr;
        mismatch_q    <= 1'b0;
        status_q      <= STATUS_OK;
        run_cycles_q  <= 16'd0;
      end
      if (state == ST_READ) begin
        mismatch_q <= verify_bad;
        if ((beat == ADDR_CCR) && verify_bad) begin
          status_q <= STATUS_VERIFY_FAIL;
        end
      end
      if (state == ST_RUN) begin
        run_cycles_q <= sat_inc16(run_cycles_q);
        if (run_exit) begin
          status_q   <= exit_status;
          last_dir_q <= bus.dir;
        end
      end
    end
  end

  udc_bus_driver u_bus_driver (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd),
    .ncs   (bus.ncs),
    .nrd   (bus.nrd),
    .nwr   (bus.nwr),
    .a0    (bus.a0),
    .a1    (bus.a1),
    .din   (din),
    .rdata (rdata)
  );

  assign bus.cfg_ready  = (state == ST_IDLE);
  assign bus.start      = start_q;
  assign bus.done       = done_q;
  assign bus.status     = status_q;
  assign bus.run_cycles = run_cycles_q;
  assign bus.last_dir   = last_dir_q;

endmodule

`default_nettype wire

// File: tb/tb_udc_host_sequencer.sv
// tb_udc_host_sequencer: scoreboard bench with a small counter-peripheral model on the din bus.
// Rev 1.0
`default_nettype none

module tb_udc_host_sequencer;
  import udc_pkg::*;

  typedef struct {
    int         cyc;
    logic [11:0] beat;
  } wr_exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  st;
    logic [15:0] rc;
    bit          chk_dir;
    logic        dir;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  udc_host_sequencer_if bus_a ();
  udc_host_sequencer_if bus_b ();
  wire [7:0] din_a;
  wire [7:0] din_b;

  udc_host_sequencer #(.VERIFY(1'b1), .TIMEOUT(16)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .din   (din_a)
  );

  udc_host_sequencer #(.VERIFY(1'b0), .TIMEOUT(1024)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .din   (din_b)
  );

  // Counter register model: captures writes, answers read beats.
  logic [7:0] model_reg [4];
  logic [7:0] rd_val;
  bit         corrupt = 1'b0;

  always @(posedge clk) begin
    if (!bus_a.ncs && !bus_a.nwr) model_reg[{bus_a.a1, bus_a.a0}] <= din_a;
  end

  always_comb begin
    rd_val = model_reg[{bus_a.a1, bus_a.a0}];
    if (corrupt && ({bus_a.a1, bus_a.a0} == ADDR_PLR)) rd_val = 8'd9;
  end

  assign din_a = (!bus_a.ncs && !bus_a.nrd) ? rd_val : 8'bz;

  int        checks = 0;
  int        errors = 0;
  int        start_count = 0;
  int        t0 = 0;
  bit        mon_en = 1'b0;
  wr_exp_t   wr_q [$];
  done_exp_t done_q [$];
  wr_exp_t   mw;
  done_exp_t md;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus_a.nwr) begin
        if (wr_q.size() == 0) begin
          check_val("wr_unexpected", {20'd0, bus_a.ncs, bus_a.nrd, bus_a.a1, bus_a.a0, din_a}, 32'hFFFF_FFFF);
        end else begin
          mw = wr_q.pop_front();
          check_val("wr_beat", {20'd0, bus_a.ncs, bus_a.nrd, bus_a.a1, bus_a.a0, din_a}, {20'd0, mw.beat});
          check_val("wr_cycle", cyc, mw.cyc);
        end
      end
      if (bus_a.start) start_count++;
      if (bus_a.done) begin
        if (done_q.size() == 0) begin
          check_val("done_unexpected", {31'd0, bus_a.done}, 32'd0);
        end else begin
          md = done_q.pop_front();
          check_val("done_cycle", cyc, md.cyc);
          check_val("status", 32'(bus_a.status), 32'(md.st));
          check_val("run_cycles", 32'(bus_a.run_cycles), 32'(md.rc));
          if (md.chk_dir) check_val("last_dir", 32'(bus_a.last_dir), 32'(md.dir));
        end
      end
    end
  end

  task automatic push_done(input int c, input logic [1:0] st, input logic [15:0] rc,
                           input bit cd, input logic d);
    done_exp_t e;
    e.cyc = c; e.st = st; e.rc = rc; e.chk_dir = cd; e.dir = d;
    done_q.push_back(e);
  endtask

  task automatic push_writes(input int base, input int nbeats,
                             input logic [7:0] p, input logic [7:0] u,
                             input logic [7:0] l, input logic [7:0] c);
    logic [7:0] v [4];
    wr_exp_t    e;
    v[0] = p; v[1] = u; v[2] = l; v[3] = c;
    for (int k = 0; k < nbeats; k++) begin
      e.cyc  = base + 1 + k;
      e.beat = {1'b0, 1'b1, 2'(k), v[k]};
      wr_q.push_back(e);
    end
  endtask

  // Presents a request at a negedge while ready; returns one cycle after the accept cycle.
  task automatic do_cfg(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                        input logic [7:0] c, input int nbeats);
    int n = 0;
    @(negedge clk);
    while (!bus_a.cfg_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("cfg_ready_wait", {31'd0, bus_a.cfg_ready}, 32'd1);
    bus_a.cfg_valid = 1'b1;
    bus_a.cfg_plr = p; bus_a.cfg_ulr = u; bus_a.cfg_llr = l; bus_a.cfg_ccr = c;
    t0 = cyc;
    push_writes(t0, nbeats, p, u, l, c);
    @(negedge clk);
    bus_a.cfg_valid = 1'b0;
  endtask

  task automatic wait_start(output int s, input int lat);
    int n = 0;
    s = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus_a.start) begin
        s = cyc;
        break;
      end
    end
    check_val("start_latency", s - t0, lat);
  endtask

  task automatic pulse(input int n, input logic e, input logic r, input logic d);
    repeat (n) @(negedge clk);
    bus_a.ec = e; bus_a.err = r; bus_a.dir = d;
    @(negedge clk);
    bus_a.ec = 1'b0; bus_a.err = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.cfg_ready && n < 80);
    check_val("idle_reached", {31'd0, bus_a.cfg_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         s;
    int         sc;
    int         tb0;
    int         n;
    logic [7:0] bv [4];

    bus_a.cfg_valid = 1'b0; bus_a.cfg_plr = 8'd0; bus_a.cfg_ulr = 8'd0;
    bus_a.cfg_llr = 8'd0; bus_a.cfg_ccr = 8'd0;
    bus_a.ec = 1'b0; bus_a.err = 1'b0; bus_a.dir = 1'b0;
    bus_b.cfg_valid = 1'b0; bus_b.cfg_plr = 8'd0; bus_b.cfg_ulr = 8'd0;
    bus_b.cfg_llr = 8'd0; bus_b.cfg_ccr = 8'd0;
    bus_b.ec = 1'b0; bus_b.err = 1'b0; bus_b.dir = 1'b0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_strobes", {29'd0, bus_a.ncs, bus_a.nrd, bus_a.nwr}, 32'd7);
    check_val("rst_addr", {30'd0, bus_a.a1, bus_a.a0}, 32'd0);
    check_val("rst_start_done", {30'd0, bus_a.start, bus_a.done}, 32'd0);
    check_val("rst_status", 32'(bus_a.status), 32'd0);
    check_val("rst_run_cycles", 32'(bus_a.run_cycles), 32'd0);
    check_val("rst_last_dir", {31'd0, bus_a.last_dir}, 32'd0);
    check_val("rst_cfg_ready", {31'd0, bus_a.cfg_ready}, 32'd1);
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic run with verification and ec in RUN cycle 12.
    do_cfg(8'd10, 8'd15, 8'd5, 8'd2, 4);
    wait_start(s, 10);
    push_done(s + 13, STATUS_OK, 16'd12, 1'b1, 1'b1);
    pulse(12, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Readback returns 9 for PLR.
    corrupt = 1'b1;
    sc = start_count;
    do_cfg(8'd10, 8'd15, 8'd5, 8'd2, 4);
    push_done(t0 + 10, STATUS_VERIFY_FAIL, 16'd0, 1'b0, 1'b0);
    wait_idle();
    check_val("verify_fail_no_start", sc, start_count);
    corrupt = 1'b0;

    // err and ec together in RUN cycle 3.
    do_cfg(8'd20, 8'd40, 8'd3, 8'd1, 4);
    wait_start(s, 10);
    push_done(s + 4, STATUS_CNT_ERR, 16'd3, 1'b1, 1'b0);
    pulse(3, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // ec never arrives: TIMEOUT=16.
    do_cfg(8'd100, 8'd200, 8'd50, 8'd3, 4);
    bus_a.dir = 1'b1;
    wait_start(s, 10);
    push_done(s + 17, STATUS_TIMEOUT, 16'd16, 1'b1, 1'b1);
    wait_idle();

    // Reset in cycle T+2: only beats 0 and 1 appear.
    do_cfg(8'd1, 8'd2, 8'd3, 8'd4, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_strobes", {30'd0, bus_a.ncs, bus_a.nwr}, 32'd3);
    check_val("mid_rst_ready", {31'd0, bus_a.cfg_ready}, 32'd1);
    check_val("mid_rst_start", {31'd0, bus_a.start}, 32'd0);
    do_cfg(8'd30, 8'd35, 8'd25, 8'd7, 4);
    wait_start(s, 10);
    push_done(s + 6, STATUS_OK, 16'd5, 1'b1, 1'b1);
    pulse(5, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // cfg_valid held through RUN is only taken after DONE.
    do_cfg(8'd11, 8'd22, 8'd12, 8'd3, 4);
    wait_start(s, 10);
    bus_a.cfg_valid = 1'b1;
    bus_a.cfg_plr = 8'd50; bus_a.cfg_ulr = 8'd60; bus_a.cfg_llr = 8'd40; bus_a.cfg_ccr = 8'd5;
    push_done(s + 5, STATUS_OK, 16'd4, 1'b1, 1'b0);
    pulse(4, 1'b1, 1'b0, 1'b0);
    check_val("b2b_busy_in_done", {31'd0, bus_a.cfg_ready}, 32'd0);
    @(negedge clk);
    check_val("b2b_ready_after_done", {31'd0, bus_a.cfg_ready}, 32'd1);
    t0 = cyc;
    push_writes(t0, 4, 8'd50, 8'd60, 8'd40, 8'd5);
    @(negedge clk);
    bus_a.cfg_valid = 1'b0;
    wait_start(s, 10);
    push_done(s + 3, STATUS_OK, 16'd2, 1'b1, 1'b1);
    pulse(2, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // VERIFY=0 instance: start directly after the last write beat.
    bv[0] = 8'd7; bv[1] = 8'd8; bv[2] = 8'd6; bv[3] = 8'd1;
    n = 0;
    @(negedge clk);
    while (!bus_b.cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus_b.cfg_valid = 1'b1;
    bus_b.cfg_plr = bv[0]; bus_b.cfg_ulr = bv[1]; bus_b.cfg_llr = bv[2]; bus_b.cfg_ccr = bv[3];
    tb0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus_b.cfg_valid = 1'b0;
      if (k <= 4) begin
        check_val("nv_wr_beat", {20'd0, bus_b.ncs, bus_b.nwr, bus_b.a1, bus_b.a0, din_b},
                  {20'd0, 2'b00, 2'(k - 1), bv[k - 1]});
      end
      check_val("nv_start", {31'd0, bus_b.start}, (k == 5) ? 32'd1 : 32'd0);
    end
    check_val("nv_start_cycle", cyc - tb0, 32'd5);
    @(negedge clk);
    bus_b.ec = 1'b1;
    @(negedge clk);
    bus_b.ec = 1'b0;
    check_val("nv_done", {31'd0, bus_b.done}, 32'd1);
    check_val("nv_status", 32'(bus_b.status), 32'(STATUS_OK));
    check_val("nv_run_cycles", 32'(bus_b.run_cycles), 32'd1);

    repeat (3) @(negedge clk);
    check_val("wr_queue_empty", wr_q.size(), 32'd0);
    check_val("done_queue_empty", done_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/udc_host_sequencer.md
# udc_host_sequencer

Bus initiator for the 8-bit up/down counter peripheral (`up_down_counter255`). It accepts one configuration request and writes PLR, ULR, LLR and CCR over the shared `din` bus, optionally reads them back to verify, and issues the one-cycle `start` pulse. It then supervises the count until `ec` or `err` and returns a single status word. It sits between the system controller and the counter and owns `ncs`, `nrd`, `nwr`, `a0`, `a1` and `start`.

## Interface
- `VERIFY`, 1: 1 = read back all four registers after writing; 0 = skip readback.
- `TIMEOUT`, 1024: maximum RUN cycles without `ec` before aborting. Must fit in 16 bits.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: high only in IDLE.
- `cfg_plr`, `cfg_ulr`, `cfg_llr`, `cfg_ccr` in 8 each: values to program; captured on the accept edge.
- `din` inout 8: counter data bus. Driven only while `nwr`=0, otherwise `8'bz`.
- `ncs`, `nrd`, `nwr` out 1 each: active-low chip select, read strobe, write strobe.
- `a0`, `a1` out 1 each: register address `{a1,a0}`: 0 = PLR, 1 = ULR, 2 = LLR, 3 = CCR.
- `start` out 1: one-cycle count-start pulse.
- `ec` in 1: end of count from the counter.
- `err` in 1: error from the counter.
- `dir` in 1: counter direction; sampled into `last_dir`.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: 0 = OK, 1 = VERIFY_FAIL, 2 = CNT_ERR, 3 = TIMEOUT. Valid from `done` until the next accept.
- `run_cycles` out 16: RUN cycles until `ec`, `err` or timeout.
- `last_dir` out 1: `dir` sampled on the RUN exit edge.

## Operation
- **States:** IDLE → WRITE → TURN → READ → START → RUN → DONE → IDLE. TURN and READ are skipped when `VERIFY`=0.
- **IDLE:**
  - `ncs`=`nrd`=`nwr`=1, `start`=0, bus released.
  - `cfg_valid`&&`cfg_ready` captures all four values, clears `status`/`run_cycles`, and enters WRITE with beat index 0.
- **WRITE:** four beats, one per cycle.
  - Each beat: `ncs`=0, `nwr`=0, `nrd`=1, `{a1,a0}`=beat index, `din`=captured value for that address.
  - After beat 3 go to TURN (or START when `VERIFY`=0).
- **TURN:** one cycle with `ncs`=0, `nwr`=`nrd`=1 and the bus released.
- **READ:** four beats.
  - Each beat: `ncs`=0, `nrd`=0, `{a1,a0}`=beat index.
  - `din` is sampled on the edge ending the beat and compared with the captured value.
  - Any mismatch sets a sticky flag. After beat 3, a set flag → DONE with VERIFY_FAIL (no `start`); otherwise → START.
- **START:** one cycle with `start`=1, `ncs`=0, strobes high.
- **RUN:**
  - `ncs`=0, strobes high; `run_cycles` increments each cycle, saturating at 16'hFFFF.
  - `err`=1 → DONE with CNT_ERR.
  - Else `ec`=1 → DONE with OK.
  - Else `run_cycles`==`TIMEOUT`-1 → DONE with TIMEOUT.
- **DONE:** `done`=1 for one cycle, `ncs`=1, then IDLE.
- **Priority:** `err` beats `ec` in the same cycle, and both beat timeout.
- `ec` and `err` are ignored outside RUN.
- `cfg_valid` outside IDLE is ignored; no queueing.
- There is no range check of PLR/ULR/LLR; limit violations are reported by the counter via `err`.

## Timing
- **Reset values:** `ncs`=`nrd`=`nwr`=1, `a0`=`a1`=0, `start`=0, `din`=Z, `done`=0, `status`=0, `run_cycles`=0, `last_dir`=0, state IDLE, `cfg_ready`=1.
- **Cycle schedule** (accept edge = cycle T):
  - WRITE beats: T+1..T+4.
  - TURN: T+5.
  - READ beats: T+6..T+9.
  - `start`: T+10 (T+5 when `VERIFY`=0).
  - RUN begins: T+11.
- **Completion:** `ec` sampled high in RUN cycle R → `done` in cycle R+1 and `cfg_ready` in R+2.
- **All outputs are registered.** `cfg_ready` is decoded from the state register.
- **Bus release:** the `din` driver is enabled only in WRITE. The following cycle is never a read beat, which guarantees a turnaround.
- **Reset mid-transaction:** any state returns to IDLE on the same edge. Strobes deassert, the bus is released, no `done` is issued, and a pending `start` is dropped.

## Structure
- **Package `udc_pkg`:** address constants `ADDR_PLR`/`ADDR_ULR`/`ADDR_LLR`/`ADDR_CCR`, the `status` encodings, and the state enum. The counter and its bench reuse them.
- **Sub-module `udc_bus_driver`:**
  - Registers `ncs`/`nrd`/`nwr`/`a0`/`a1`, owns the `din` tristate, and returns the sampled read data.
  - Commanded per cycle by the FSM with {idle, write, read, addr, wdata}.

## Test plan
- **Basic run:** PLR=10, ULR=15, LLR=5, CCR=2, `VERIFY`=1 → writes 10, 15, 5, 2 at addr 0..3 in T+1..T+4; reads match; `start` at T+10; model `ec` after 12 cycles → `done` with `status`=0, `run_cycles`=12.
- **Readback corruption:** model returns 9 for PLR → `status`=1, `start` never asserted, `done` at T+10.
- **Counter error:** model raises `err` and `ec` together in RUN cycle 3 → `status`=2, `run_cycles`=3.
- **Timeout:** `TIMEOUT`=16 and `ec` held low → `done` after 16 RUN cycles with `status`=3.
- **Reset mid-write:** `reset` asserted at T+2 → next cycle `ncs`=`nwr`=1, `din`=Z, `cfg_ready`=1, no `done`. A fresh request then completes normally.
- **Back-to-back and `VERIFY`=0:**
  - `cfg_valid` held during RUN is ignored and accepted only after DONE.
  - With `VERIFY`=0, `start` appears at T+5.
